// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: pipeline bundle, memory access kinds, branch conditions.
package mem_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [2:0] {
        LoadByte  = 3'd0,
        LoadHalf  = 3'd1,
        LoadWord  = 3'd2,
        LoadByteU = 3'd3,
        LoadHalfU = 3'd4
    } MemType;

    typedef enum logic [2:0] {
        Never  = 3'd0,
        Always = 3'd1,
        Eq     = 3'd2,
        Ne     = 3'd3,
        Lt     = 3'd4,
        Ge     = 3'd5,
        Ltu    = 3'd6,
        Geu    = 3'd7
    } Cond;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Req  = 2'd1,
        Resp = 2'd2
    } MemState;

    typedef struct packed {
        logic zero;
        logic carry;
    } Flags;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] reg2;
        logic              wback;
        logic [REG_W-1:0]  wreg;
        logic [WORD_W-1:0] wdata;
        logic [WORD_W-1:0] branch;
        Flags              flags;
        Cond               cond;
        logic              memr;
        logic              memw;
        MemType            memt;
    } Signals;

    // Branch resolution from ALU flags; the ALU reports signed/unsigned less-than on carry.
    function automatic logic cond_true(input Cond c, input Flags f);
        case (c)
            Always:   return 1'b1;
            Eq:       return f.zero;
            Ne:       return !f.zero;
            Lt, Ltu:  return f.carry;
            Ge, Geu:  return !f.carry;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic is_byte(input MemType m);
        return (m == LoadByte) || (m == LoadByteU);
    endfunction

    function automatic logic is_half(input MemType m);
        return (m == LoadHalf) || (m == LoadHalfU);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane handling: store replication/byte enables, load extraction, misalignment detect.
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]        st_off,
    input  MemType            st_memt,
    input  logic [WORD_W-1:0] st_src,
    output logic [WORD_W-1:0] st_data,
    output logic [3:0]        st_be,
    output logic              misalign,
    input  logic [1:0]        ld_off,
    input  MemType            ld_memt,
    input  logic [WORD_W-1:0] ld_rdata,
    output logic [WORD_W-1:0] ld_data
);

    logic [WORD_W-1:0] ld_shift;

    // Store side: lane replication, byte enables and alignment check for the incoming op.
    always_comb begin
        st_data  = st_src;
        st_be    = 4'b1111;
        misalign = |st_off;
        if (is_byte(st_memt)) begin
            st_data  = {4{st_src[7:0]}};
            st_be    = 4'b0001 << st_off;
            misalign = 1'b0;
        end else if (is_half(st_memt)) begin
            st_data  = {2{st_src[15:0]}};
            st_be    = 4'b0011 << st_off;
            misalign = st_off[0];
        end
    end

    // Load side: bring the addressed lane down to bit 0, then sign/zero extend.
    always_comb begin
        ld_shift = ld_rdata >> {ld_off, 3'b000};
        case (ld_memt)
            LoadByte:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            LoadByteU: ld_data = {24'h0, ld_shift[7:0]};
            LoadHalf:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            LoadHalfU: ld_data = {16'h0, ld_shift[15:0]};
            default:   ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: branch resolution, load/store over a req/gnt/rvalid port, write-back bundle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  Signals          i_signals,
    output logic            o_stall,
    output Signals          o_signals,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_target,
    output logic            o_misalign,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    MemState           state;
    logic [1:0]        acc_off;
    MemType            acc_memt;
    logic              acc_store;
    logic [REG_W-1:0]  acc_wreg;
    logic              acc_wback;
    logic [WORD_W-1:0] acc_pc;

    logic              is_mem;
    logic [WORD_W-1:0] st_data;
    logic [3:0]        st_be;
    logic              misalign;
    logic [WORD_W-1:0] ld_data;

    assign is_mem = i_signals.valid && (i_signals.memr || i_signals.memw);

    mem_stage_align u_align (
        .st_off   (i_signals.wdata[1:0]),
        .st_memt  (i_signals.memt),
        .st_src   (i_signals.reg2),
        .st_data  (st_data),
        .st_be    (st_be),
        .misalign (misalign),
        .ld_off   (acc_off),
        .ld_memt  (acc_memt),
        .ld_rdata (dmem_rdata),
        .ld_data  (ld_data)
    );

    // Upstream hold: high while an access is pending, dropped on the completing cycle.
    always_comb begin
        o_stall = 1'b0;
        if (!rst) begin
            case (state)
                Idle:    o_stall = is_mem && !misalign;
                Req:     o_stall = !(dmem_gnt && acc_store);
                Resp:    o_stall = !dmem_rvalid;
                default: o_stall = 1'b0;
            endcase
        end
    end

    // Access FSM with registered write-back bundle, redirect and misalign pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= Idle;
            acc_off    <= 2'b00;
            acc_memt   <= LoadByte;
            acc_store  <= 1'b0;
            acc_wreg   <= '0;
            acc_wback  <= 1'b0;
            acc_pc     <= '0;
            o_signals  <= '0;
            o_redirect <= 1'b0;
            o_target   <= '0;
            o_misalign <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
        end else begin
            o_signals  <= '0;
            o_redirect <= 1'b0;
            o_misalign <= 1'b0;
            case (state)
                Idle: begin
                    if (i_signals.valid && cond_true(i_signals.cond, i_signals.flags)) begin
                        o_redirect <= 1'b1;
                        o_target   <= i_signals.branch;
                    end
                    if (is_mem) begin
                        if (misalign) begin
                            o_misalign <= 1'b1;
                        end else begin
                            acc_off    <= i_signals.wdata[1:0];
                            acc_memt   <= i_signals.memt;
                            acc_store  <= i_signals.memw;
                            acc_wreg   <= i_signals.wreg;
                            acc_wback  <= i_signals.wback;
                            acc_pc     <= i_signals.pc;
                            dmem_req   <= 1'b1;
                            dmem_we    <= i_signals.memw;
                            dmem_addr  <= {i_signals.wdata[WORD_W-1:2], 2'b00};
                            dmem_be    <= i_signals.memw ? st_be : 4'b0000;
                            dmem_wdata <= i_signals.memw ? st_data : '0;
                            state      <= Req;
                        end
                    end else if (i_signals.valid) begin
                        o_signals.valid <= 1'b1;
                        o_signals.pc    <= i_signals.pc;
                        o_signals.wback <= i_signals.wback;
                        o_signals.wreg  <= i_signals.wreg;
                        o_signals.wdata <= i_signals.wdata;
                    end
                end
                Req: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (acc_store) begin
                            o_signals.valid <= 1'b1;
                            o_signals.pc    <= acc_pc;
                            o_signals.wreg  <= acc_wreg;
                            state           <= Idle;
                        end else begin
                            state <= Resp;
                        end
                    end
                end
                Resp: begin
                    if (dmem_rvalid) begin
                        o_signals.valid <= 1'b1;
                        o_signals.pc    <= acc_pc;
                        o_signals.wback <= acc_wback;
                        o_signals.wreg  <= acc_wreg;
                        o_signals.wdata <= ld_data;
                        state           <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule
